// File: rtl/eth_tx_arbiter.sv
// -----------------------------------------------------------------------------
// eth_tx_arbiter
//
// Shares one byte-wide Ethernet transmit path between NREQ frame sources.
// Whole frames are granted round-robin; the winner's SoF/Val/EoF/Data beats
// are muxed through one register stage to the MAC side. Every frame end
// (EoF beat, truncation at MAX_LEN, or start timeout) is followed by an
// inter-frame gap of IFG_CYCLES idle cycles before the next grant decision.
//
// Beat handshake: there is no backpressure. A source may present a beat
// only while its GntOut bit is high; a beat is taken on every rising Clk
// edge where ValIn[i] is high for the granted lane. On the MAC side a beat
// is present on every cycle where ValOut is high and must be consumed in
// that cycle. SoF/EoF qualify the beat only while the matching valid is high.
//
// Ports
//   Clk          in   1        system clock, rising edge
//   nReset       in   1        asynchronous active-low reset
//   ReqIn        in   NREQ     level request per source
//   SoFIn        in   NREQ     start-of-frame per source (qualified by ValIn)
//   EoFIn        in   NREQ     end-of-frame per source (qualified by ValIn)
//   ValIn        in   NREQ     byte valid per source
//   DataIn       in   8*NREQ   byte per source, source i on [8*i+7:8*i]
//   GntOut       out  NREQ     one-hot grant, registered
//   SoFOut       out  1        start-of-frame to MAC
//   EoFOut       out  1        end-of-frame to MAC
//   ValOut       out  1        byte valid to MAC
//   DataOut      out  8        byte to MAC (holds when ValOut is low)
//   ErrOut       out  1        pulse with the beat that truncates a frame
//   TimeoutOut   out  1        pulse when a grant is revoked for no SoF
//   BusyOut      out  1        high whenever the arbiter is not IDLE
//   DbgStateOut  out  2        current FSM state (0 IDLE,1 GRANT,2 XFER,3 GAP)
// -----------------------------------------------------------------------------
module eth_tx_arbiter #(
    parameter int NREQ       = 2,
    parameter int IFG_CYCLES = 12,
    parameter int START_TO   = 1024,
    parameter int MAX_LEN    = 1518
) (
    input  logic              Clk,
    input  logic              nReset,
    input  logic [NREQ-1:0]   ReqIn,
    input  logic [NREQ-1:0]   SoFIn,
    input  logic [NREQ-1:0]   EoFIn,
    input  logic [NREQ-1:0]   ValIn,
    input  logic [8*NREQ-1:0] DataIn,
    output logic [NREQ-1:0]   GntOut,
    output logic              SoFOut,
    output logic              EoFOut,
    output logic              ValOut,
    output logic [7:0]        DataOut,
    output logic              ErrOut,
    output logic              TimeoutOut,
    output logic              BusyOut,
    output logic [1:0]        DbgStateOut
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Terminal counts for the 16-bit counters. The timer is compared
    // against START_TO-1 so that the grant is held for exactly START_TO
    // cycles; the gap counter likewise ends after IFG_CYCLES cycles.
    localparam logic [15:0] START_LAST = 16'(START_TO - 1);
    localparam logic [15:0] MAX_LEN_W  = 16'(MAX_LEN);
    localparam logic [15:0] GAP_LAST   = (IFG_CYCLES > 0) ? 16'(IFG_CYCLES - 1) : 16'd0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_XFER  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // State and registered outputs
    // -------------------------------------------------------------------------
    state_t            state_q,   state_d;
    logic [IDXW-1:0]   last_q,    last_d;     // last-served index, also the granted lane
    logic [NREQ-1:0]   gnt_q,     gnt_d;
    logic [15:0]       timer_q,   timer_d;    // cycles spent in GRANT
    logic [15:0]       beat_q,    beat_d;     // beats forwarded in the current frame
    logic [15:0]       gap_q,     gap_d;      // cycles spent in GAP
    logic              sof_q,     sof_d;
    logic              eof_q,     eof_d;
    logic              val_q,     val_d;
    logic [7:0]        data_q,    data_d;
    logic              err_q,     err_d;
    logic              to_q,      to_d;
    logic              busy_q,    busy_d;

    // Granted-lane view of the inputs. Only this lane is ever looked at.
    logic              lane_val;
    logic              lane_sof;
    logic              lane_eof;
    logic [7:0]        lane_data;

    // Round-robin selection results
    logic              rr_found;
    logic [IDXW-1:0]   rr_sel;
    logic [IDXW-1:0]   rr_cand;

    // Saturating increment; with the legal parameter ranges the counters
    // never reach the ceiling, saturation only guards against wrap.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        lane_val  = ValIn[last_q];
        lane_sof  = SoFIn[last_q];
        lane_eof  = EoFIn[last_q];
        lane_data = DataIn[{last_q, 3'b000} +: 8];
    end

    // First requesting index after the last-served one, wrapping modulo NREQ.
    // Starting the search at last+1 and ending at last itself gives a fair
    // rotation where the last-served source has the lowest priority.
    always_comb begin
        rr_found = 1'b0;
        rr_sel   = '0;
        rr_cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            rr_cand = IDXW'((int'(last_q) + k) % NREQ);
            if (!rr_found && ReqIn[rr_cand]) begin
                rr_found = 1'b1;
                rr_sel   = rr_cand;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        timer_d = timer_q;
        beat_d  = beat_q;
        gap_d   = gap_q;
        // Beat strobes and pulses are single-cycle unless re-asserted below.
        sof_d   = 1'b0;
        eof_d   = 1'b0;
        val_d   = 1'b0;
        err_d   = 1'b0;
        to_d    = 1'b0;
        // DataOut holds its last value between beats.
        data_d  = data_q;

        unique case (state_q)
            ST_IDLE: begin
                if (rr_found) begin
                    state_d = ST_GRANT;
                    last_d  = rr_sel;
                    gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << rr_sel;
                    timer_d = 16'd0;
                end
            end

            ST_GRANT: begin
                // A SoF beat on the last allowed cycle still wins over the
                // timeout. Valid beats without SoF are silently discarded.
                if (lane_val && lane_sof) begin
                    val_d  = 1'b1;
                    sof_d  = 1'b1;
                    data_d = lane_data;
                    beat_d = 16'd1;
                    if (lane_eof) begin
                        // Single-beat frame: SoF and EoF together.
                        eof_d   = 1'b1;
                        gnt_d   = '0;
                        gap_d   = 16'd0;
                        state_d = ST_GAP;
                    end else begin
                        state_d = ST_XFER;
                    end
                end else if (timer_q == START_LAST) begin
                    gnt_d   = '0;
                    to_d    = 1'b1;
                    gap_d   = 16'd0;
                    state_d = ST_GAP;
                end else begin
                    timer_d = sat_inc(timer_q);
                end
            end

            ST_XFER: begin
                if (lane_val) begin
                    // SoFIn is deliberately not looked at here: a repeated
                    // SoF mid-frame travels as ordinary data.
                    val_d  = 1'b1;
                    data_d = lane_data;
                    beat_d = sat_inc(beat_q);
                    if (lane_eof) begin
                        eof_d   = 1'b1;
                        gnt_d   = '0;
                        gap_d   = 16'd0;
                        state_d = ST_GAP;
                    end else if (sat_inc(beat_q) == MAX_LEN_W) begin
                        // Truncation: close the frame on the MAC side and
                        // flag it; the source's remaining beats are dropped
                        // because it no longer holds the grant.
                        eof_d   = 1'b1;
                        err_d   = 1'b1;
                        gnt_d   = '0;
                        gap_d   = 16'd0;
                        state_d = ST_GAP;
                    end
                end
            end

            ST_GAP: begin
                if (gap_q >= GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = sat_inc(gap_q);
                end
            end

            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // -------------------------------------------------------------------------
    // Registers. Asynchronous reset drops every output at once, so a frame
    // cut by reset simply ends without an EoF beat.
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= ST_IDLE;
            last_q  <= IDXW'(NREQ - 1);
            gnt_q   <= '0;
            timer_q <= 16'd0;
            beat_q  <= 16'd0;
            gap_q   <= 16'd0;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
            val_q   <= 1'b0;
            data_q  <= 8'd0;
            err_q   <= 1'b0;
            to_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            timer_q <= timer_d;
            beat_q  <= beat_d;
            gap_q   <= gap_d;
            sof_q   <= sof_d;
            eof_q   <= eof_d;
            val_q   <= val_d;
            data_q  <= data_d;
            err_q   <= err_d;
            to_q    <= to_d;
            busy_q  <= busy_d;
        end
    end

    assign GntOut      = gnt_q;
    assign SoFOut      = sof_q;
    assign EoFOut      = eof_q;
    assign ValOut      = val_q;
    assign DataOut     = data_q;
    assign ErrOut      = err_q;
    assign TimeoutOut  = to_q;
    assign BusyOut     = busy_q;
    assign DbgStateOut = state_q;

endmodule
